mem_port_arbiter: RTL and testbench

//  Shares one single-port, byte-masked, 1-cycle-read-latency memory bank between
//  an instruction-fetch requester (read-only, word) and a data requester
//  (read/write, byte/half/word).

---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/mem_lane_align.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter:
//   - WORD_BYTES : bytes per bank word (32-bit datapath)
//   - SZ_*       : data access size encodings (2'b11 is reserved)
//   - own_e      : response-owner state, i.e. who receives data the cycle after grant
//   - is_aligned : natural-alignment check for a data access
package mem_arb_pkg;

  localparam int WORD_BYTES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IFETCH = 2'd1,
    OWN_DATA   = 2'd2,
    OWN_DERR   = 2'd3
  } own_e;

  // A reserved size is never considered aligned, so a single check covers both error cases.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for the memory port arbiter. Purely combinational.
//   Store side: i_st_size/i_st_off/i_st_wdata -> o_st_mask (byte enables),
//               o_st_wdata (byte or half replicated across all lanes).
//   Load side:  i_ld_size/i_ld_off/i_ld_unsigned/i_ld_rdata -> o_ld_data
//               (bank word shifted down by the byte offset, then sign- or
//               zero-extended from the access size).
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]            i_st_size,
  input  logic [1:0]            i_st_off,
  input  logic [31:0]           i_st_wdata,
  output logic [WORD_BYTES-1:0] o_st_mask,
  output logic [31:0]           o_st_wdata,
  input  logic [1:0]            i_ld_size,
  input  logic [1:0]            i_ld_off,
  input  logic                  i_ld_unsigned,
  input  logic [31:0]           i_ld_rdata,
  output logic [31:0]           o_ld_data
);

  logic [31:0] w_shifted;

  always_comb begin
    o_st_mask  = '0;
    o_st_wdata = i_st_wdata;
    case (i_st_size)
      SZ_BYTE: begin
        o_st_mask  = 4'b0001 << i_st_off;
        o_st_wdata = {4{i_st_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_st_mask  = 4'b0011 << i_st_off;
        o_st_wdata = {2{i_st_wdata[15:0]}};
      end
      SZ_WORD: begin
        o_st_mask  = 4'b1111;
        o_st_wdata = i_st_wdata;
      end
      default: begin
        o_st_mask  = '0;
        o_st_wdata = i_st_wdata;
      end
    endcase
  end

  always_comb begin
    w_shifted = i_ld_rdata >> {i_ld_off, 3'b000};
    o_ld_data = w_shifted;
    case (i_ld_size)
      SZ_BYTE: o_ld_data = i_ld_unsigned ? {24'd0, w_shifted[7:0]}
                                         : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_ld_data = i_ld_unsigned ? {16'd0, w_shifted[15:0]}
                                         : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: o_ld_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, byte-masked, 1-cycle-read-latency bank between an
// instruction fetch port (word reads) and a data port (byte/half/word loads
// and stores). One access is granted per cycle; the response is returned the
// cycle after grant to whichever requester owns it.
//
// Ports:
//   clk, rst_n_i                         clock, async active-low reset
//   i_req_i/i_addr_i -> i_gnt_o          fetch request / grant (combinational)
//   i_rvalid_o/i_rdata_o                 fetch response
//   d_req_i/d_we_i/d_addr_i/d_size_i/
//   d_unsigned_i/d_wdata_i -> d_gnt_o    data request / grant (combinational)
//   d_rvalid_o/d_rdata_o/d_err_o         data response (err on misaligned/reserved)
//   mem_*_o, mem_rd_data_i               bank interface
//   dbg_owner_o                          current response-owner state
//
// Handshake: a request is accepted in the cycle its gnt is high; req must be
// held until then. The response (rvalid or err) appears exactly one cycle
// later and cannot be stalled.
//
// Configuration macro MEM_ARB_RR_EN: defined -> round-robin on contention,
// undefined -> data port has fixed priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int DEPTH  = 512,
  parameter  int WIDTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH * WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic                  i_req_i,
  input  logic [ADDR_W-1:0]     i_addr_i,
  output logic                  i_gnt_o,
  output logic                  i_rvalid_o,
  output logic [31:0]           i_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_W-1:0]     d_addr_i,
  input  logic [1:0]            d_size_i,
  input  logic                  d_unsigned_i,
  input  logic [31:0]           d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [31:0]           d_rdata_o,
  output logic                  d_err_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [31:0]           mem_wr_data_o,
  output logic [WORD_BYTES-1:0] mem_bytemask_o,
  output logic                  mem_write_en_o,
  output logic                  mem_read_en_o,
  input  logic [31:0]           mem_rd_data_i,
  output own_e                  dbg_owner_o
);

  own_e                  r_owner;
  own_e                  w_owner_nxt;
  logic [1:0]            r_ld_off;
  logic [1:0]            r_ld_size;
  logic                  r_ld_uns;
  logic                  w_i_req;
  logic                  w_d_req;
  logic                  w_prio_data;
  logic                  w_d_ok;
  logic                  w_ld_latch;
  logic [WORD_BYTES-1:0] w_st_mask;
  logic [31:0]           w_st_wdata;
  logic [31:0]           w_ld_data;

  // Requests are masked during reset so no grant or bank strobe escapes.
  assign w_i_req = i_req_i & rst_n_i;
  assign w_d_req = d_req_i & rst_n_i;

`ifdef MEM_ARB_RR_EN
  // 1 = data wins the next contested cycle. Moves only on contested grants.
  logic r_rr_data;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rr_data <= 1'b1;
    end else if (w_i_req && w_d_req) begin
      r_rr_data <= i_gnt_o;
    end
  end

  assign w_prio_data = r_rr_data;
`else
  assign w_prio_data = 1'b1;
`endif

  assign d_gnt_o = w_d_req & (~w_i_req | w_prio_data);
  assign i_gnt_o = w_i_req & ~d_gnt_o;

  assign w_d_ok     = is_aligned(d_size_i, d_addr_i[1:0]);
  assign w_ld_latch = d_gnt_o & w_d_ok & ~d_we_i;

  mem_lane_align u_align (
    .i_st_size     (d_size_i),
    .i_st_off      (d_addr_i[1:0]),
    .i_st_wdata    (d_wdata_i),
    .o_st_mask     (w_st_mask),
    .o_st_wdata    (w_st_wdata),
    .i_ld_size     (r_ld_size),
    .i_ld_off      (r_ld_off),
    .i_ld_unsigned (r_ld_uns),
    .i_ld_rdata    (mem_rd_data_i),
    .o_ld_data     (w_ld_data)
  );

  // Owner state register.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // Load formatting context, captured at load grant for use on the response.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ld_off  <= 2'b00;
      r_ld_size <= 2'b00;
      r_ld_uns  <= 1'b0;
    end else if (w_ld_latch) begin
      r_ld_off  <= d_addr_i[1:0];
      r_ld_size <= d_size_i;
      r_ld_uns  <= d_unsigned_i;
    end
  end

  // Next owner and bank drive. Stores need no response, so they leave the
  // owner at NONE; a rejected data access drives nothing but owns an error.
  always_comb begin
    w_owner_nxt    = OWN_NONE;
    mem_addr_o     = '0;
    mem_wr_data_o  = '0;
    mem_bytemask_o = '0;
    mem_write_en_o = 1'b0;
    mem_read_en_o  = 1'b0;
    if (d_gnt_o) begin
      if (w_d_ok) begin
        mem_addr_o     = d_addr_i;
        mem_bytemask_o = w_st_mask;
        if (d_we_i) begin
          mem_write_en_o = 1'b1;
          mem_wr_data_o  = w_st_wdata;
        end else begin
          mem_read_en_o = 1'b1;
          w_owner_nxt   = OWN_DATA;
        end
      end else begin
        w_owner_nxt = OWN_DERR;
      end
    end else if (i_gnt_o) begin
      mem_addr_o     = i_addr_i;
      mem_bytemask_o = '1;
      mem_read_en_o  = 1'b1;
      w_owner_nxt    = OWN_IFETCH;
    end
  end

  // Responses decode straight from the owner register.
  assign i_rvalid_o  = (r_owner == OWN_IFETCH);
  assign i_rdata_o   = i_rvalid_o ? mem_rd_data_i : 32'd0;
  assign d_rvalid_o  = (r_owner == OWN_DATA);
  assign d_rdata_o   = d_rvalid_o ? w_ld_data : 32'd0;
  assign d_err_o     = (r_owner == OWN_DERR);
  assign dbg_owner_o = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst_n_i;
  logic        i_req_i;
  logic [10:0] i_addr_i;
  logic        i_gnt_o;
  logic        i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [10:0] d_addr_i;
  logic [1:0]  d_size_i;
  logic        d_unsigned_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        d_err_o;
  logic [10:0] mem_addr_o;
  logic [31:0] mem_wr_data_o;
  logic [3:0]  mem_bytemask_o;
  logic        mem_write_en_o;
  logic        mem_read_en_o;
  logic [31:0] mem_rd_data_i;
  own_e        dbg_owner_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter dut (
    .clk            (clk),
    .rst_n_i        (rst_n_i),
    .i_req_i        (i_req_i),
    .i_addr_i       (i_addr_i),
    .i_gnt_o        (i_gnt_o),
    .i_rvalid_o     (i_rvalid_o),
    .i_rdata_o      (i_rdata_o),
    .d_req_i        (d_req_i),
    .d_we_i         (d_we_i),
    .d_addr_i       (d_addr_i),
    .d_size_i       (d_size_i),
    .d_unsigned_i   (d_unsigned_i),
    .d_wdata_i      (d_wdata_i),
    .d_gnt_o        (d_gnt_o),
    .d_rvalid_o     (d_rvalid_o),
    .d_rdata_o      (d_rdata_o),
    .d_err_o        (d_err_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wr_data_o  (mem_wr_data_o),
    .mem_bytemask_o (mem_bytemask_o),
    .mem_write_en_o (mem_write_en_o),
    .mem_read_en_o  (mem_read_en_o),
    .mem_rd_data_i  (mem_rd_data_i),
    .dbg_owner_o    (dbg_owner_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: registered read sampled before a same-edge write lands.
  logic [31:0] bank [0:511];
  int          bank_idx;
  assign bank_idx = int'(mem_addr_o) >> 2;

  always @(posedge clk) begin
    if (mem_read_en_o) mem_rd_data_i <= bank[bank_idx];
    if (mem_write_en_o) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_bytemask_o[b]) bank[bank_idx][8*b +: 8] <= mem_wr_data_o[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic idle();
    i_req_i = 1'b0;
    d_req_i = 1'b0;
  endtask

  task automatic drive_i(input logic [10:0] addr);
    i_req_i  = 1'b1;
    i_addr_i = addr;
  endtask

  task automatic drive_d(input logic we, input logic [10:0] addr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd);
    d_req_i      = 1'b1;
    d_we_i       = we;
    d_addr_i     = addr;
    d_size_i     = sz;
    d_unsigned_i = uns;
    d_wdata_i    = wd;
  endtask

  logic exp_d;
  logic prev_d;

  initial begin
    rst_n_i = 1'b0;
    i_addr_i = '0;
    drive_d(1'b0, 11'h000, SZ_WORD, 1'b0, 32'h0);
    drive_i(11'h000);
    mem_rd_data_i = '0;

    // 1. Reset held with both requests high
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("rst_i_gnt", 32'(i_gnt_o), 32'd0);
      check("rst_d_gnt", 32'(d_gnt_o), 32'd0);
      check("rst_en", {30'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
      check("rst_resp", {29'd0, i_rvalid_o, d_rvalid_o, d_err_o}, 32'd0);
    end
    @(negedge clk); idle(); rst_n_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check("post_rst_resp", {29'd0, i_rvalid_o, d_rvalid_o, d_err_o}, 32'd0);
      check("post_rst_owner", 32'(dbg_owner_o), 32'(OWN_NONE));
    end

    // Preload bank through the data port
    @(negedge clk); drive_d(1'b1, 11'h010, SZ_WORD, 1'b0, 32'hDEADBEEF); #1;
    check("st_w_gnt", 32'(d_gnt_o), 32'd1);
    check("st_w_we", 32'(mem_write_en_o), 32'd1);
    check("st_w_re", 32'(mem_read_en_o), 32'd0);
    check("st_w_mask", 32'(mem_bytemask_o), 32'hF);
    check("st_w_addr", 32'(mem_addr_o), 32'h010);
    check("st_w_data", mem_wr_data_o, 32'hDEADBEEF);
    @(negedge clk); drive_d(1'b1, 11'h014, SZ_WORD, 1'b0, 32'h55AA55AA); #1;
    check("st_no_resp", {30'd0, d_rvalid_o, d_err_o}, 32'd0);
    @(negedge clk); idle(); #1;

    // 2. Fetch
    @(negedge clk); drive_i(11'h010); #1;
    check("f_gnt", 32'(i_gnt_o), 32'd1);
    check("f_re", 32'(mem_read_en_o), 32'd1);
    check("f_mask", 32'(mem_bytemask_o), 32'hF);
    @(negedge clk); idle(); #1;
    check("f_rvalid", 32'(i_rvalid_o), 32'd1);
    check("f_rdata", i_rdata_o, 32'hDEADBEEF);
    check("f_owner", 32'(dbg_owner_o), 32'(OWN_IFETCH));
    check("f_d_rvalid", 32'(d_rvalid_o), 32'd0);
    @(negedge clk); #1;
    check("f_rvalid_drop", 32'(i_rvalid_o), 32'd0);
    check("f_rdata_zero", i_rdata_o, 32'd0);

    // 3. Byte store and byte loads
    @(negedge clk); drive_d(1'b1, 11'h013, SZ_BYTE, 1'b0, 32'h000000AB); #1;
    check("sb_mask", 32'(mem_bytemask_o), 32'h8);
    check("sb_data", mem_wr_data_o, 32'hABABABAB);
    @(negedge clk); drive_d(1'b0, 11'h013, SZ_BYTE, 1'b0, 32'h0); #1;
    check("lb_re", 32'(mem_read_en_o), 32'd1);
    check("lb_we", 32'(mem_write_en_o), 32'd0);
    check("sb_no_resp", {30'd0, d_rvalid_o, d_err_o}, 32'd0);
    @(negedge clk); drive_d(1'b0, 11'h013, SZ_BYTE, 1'b1, 32'h0); #1;
    check("lb_rvalid", 32'(d_rvalid_o), 32'd1);
    check("lb_signed", d_rdata_o, 32'hFFFFFFAB);
    @(negedge clk); drive_d(1'b0, 11'h012, SZ_HALF, 1'b0, 32'h0); #1;
    check("lbu_unsigned", d_rdata_o, 32'h000000AB);
    @(negedge clk); drive_d(1'b1, 11'h016, SZ_HALF, 1'b0, 32'h00001234); #1;
    check("lh_signed", d_rdata_o, 32'hFFFFABAD);
    check("sh_mask", 32'(mem_bytemask_o), 32'hC);
    check("sh_data", mem_wr_data_o, 32'h12341234);

    // 4. Misaligned half and reserved size
    @(negedge clk); drive_d(1'b0, 11'h011, SZ_HALF, 1'b0, 32'h0); #1;
    check("mis_gnt", 32'(d_gnt_o), 32'd1);
    check("mis_en", {30'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
    @(negedge clk); drive_d(1'b0, 11'h010, 2'b11, 1'b0, 32'h0); #1;
    check("mis_err", 32'(d_err_o), 32'd1);
    check("mis_rvalid", 32'(d_rvalid_o), 32'd0);
    check("mis_rdata", d_rdata_o, 32'd0);
    check("rsv_en", {30'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
    @(negedge clk); idle(); #1;
    check("rsv_err", 32'(d_err_o), 32'd1);
    check("rsv_owner", 32'(dbg_owner_o), 32'(OWN_DERR));
    @(negedge clk); #1;
    check("err_drop", 32'(d_err_o), 32'd0);

    // Load then store to the same word: load sees pre-store data
    @(negedge clk); drive_d(1'b0, 11'h010, SZ_WORD, 1'b0, 32'h0); #1;
    @(negedge clk); drive_d(1'b1, 11'h010, SZ_WORD, 1'b0, 32'h11111111); #1;
    check("raw_rvalid", 32'(d_rvalid_o), 32'd1);
    check("raw_old", d_rdata_o, 32'hABADBEEF);
    @(negedge clk); drive_d(1'b0, 11'h010, SZ_WORD, 1'b0, 32'h0); #1;
    @(negedge clk); idle(); #1;
    check("raw_new", d_rdata_o, 32'h11111111);
    @(negedge clk); #1;

    // 5. Contention for 6 cycles
    prev_d = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); drive_i(11'h010); drive_d(1'b0, 11'h014, SZ_WORD, 1'b0, 32'h0); #1;
      exp_d = RR ? (k % 2 == 0) : 1'b1;
      check("arb_d_gnt", 32'(d_gnt_o), 32'(exp_d));
      check("arb_i_gnt", 32'(i_gnt_o), 32'(!exp_d));
      if (k > 0) begin
        check("arb_d_rvalid", 32'(d_rvalid_o), 32'(prev_d));
        check("arb_i_rvalid", 32'(i_rvalid_o), 32'(!prev_d));
        if (prev_d) check("arb_d_rdata", d_rdata_o, 32'h123455AA);
        else        check("arb_i_rdata", i_rdata_o, 32'h11111111);
      end
      prev_d = exp_d;
    end
    @(negedge clk); idle(); #1;
    check("arb_last_d", 32'(d_rvalid_o), 32'(prev_d));
    check("arb_last_i", 32'(i_rvalid_o), 32'(!prev_d));
    @(negedge clk); #1;

    // 6. Reset falls while a fetch is being granted
    @(negedge clk); drive_i(11'h010); #1;
    check("rf_gnt", 32'(i_gnt_o), 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    check("rf_gnt_rst", 32'(i_gnt_o), 32'd0);
    check("rf_re_rst", 32'(mem_read_en_o), 32'd0);
    @(negedge clk); #1;
    check("rf_rvalid_rst", 32'(i_rvalid_o), 32'd0);
    @(negedge clk); idle(); rst_n_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check("rf_rvalid_after", 32'(i_rvalid_o), 32'd0);
      check("rf_owner_after", 32'(dbg_owner_o), 32'(OWN_NONE));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
